// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the parametrised FIFO and its storage sub-module.
// Contents:
//   DEFAULT_BITNUMBER / DEFAULT_LENGTH : default word width and depth
//   calc_cntw(length)   : width needed to hold an occupancy of 0..length
//   calc_ptrw(length)   : width of a pointer that indexes 0..length-1
//   ptr_inc(ptr,length) : pointer increment with explicit wrap at length-1
//   fifo_op_e           : which of read/write were accepted this cycle
package fifo_pkg;

    localparam int DEFAULT_BITNUMBER = 8;
    localparam int DEFAULT_LENGTH    = 8;

    // Occupancy runs from 0 to LENGTH inclusive, hence the +1.
    function automatic int calc_cntw(input int length);
        return $clog2(length + 1);
    endfunction

    function automatic int calc_ptrw(input int length);
        return (length > 1) ? $clog2(length) : 1;
    endfunction

    // Depth need not be a power of two, so wrap is an explicit compare
    // rather than letting the pointer overflow naturally.
    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned length);
        if (ptr == length - 1)
            return 0;
        else
            return ptr + 1;
    endfunction

    // Encoding matches the concatenation {write_accepted, read_accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
// LENGTH x BITNUMBER register array: one synchronous write port and one
// asynchronous read port. Kept separate so a cell-library RAM can be
// dropped in without touching the FIFO control logic.
// Ports:
//   clk      : write clock
//   wr_en    : write strobe
//   wr_addr  : write address (0..LENGTH-1)
//   wr_data  : write data
//   rd_addr  : read address (0..LENGTH-1)
//   rd_data  : combinational read data
module fifo_mem #(
    parameter int BITNUMBER = 8,
    parameter int LENGTH    = 8,
    parameter int PTRW      = 3
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [PTRW-1:0]      wr_addr,
    input  logic [BITNUMBER-1:0] wr_data,
    input  logic [PTRW-1:0]      rd_addr,
    output logic [BITNUMBER-1:0] rd_data
);

    logic [BITNUMBER-1:0] mem [LENGTH];

    // Storage is intentionally not reset; the FIFO's count decides which
    // entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, one-cycle error pulses and a sticky error.
// Ports:
//   clk, reset (sync, active-high)
//   Fifo_wr / Fifo_rd / Fifo_Data_in : requests and write data
//   umbral_alto / umbral_bajo        : almost-full / almost-empty thresholds
//   error_clr                        : clears the sticky Fifo_error
//   Fifo_Data_out                    : registered read data (latency 1)
//   Fifo_full / Fifo_empty / almost_full / almost_empty / Fifo_count :
//                                      combinational from the count register
//   Fifo_rd_error / Fifo_wr_error    : one-cycle pulses for rejected requests
//   Fifo_error                       : sticky OR of the pulses
module fifo_param
    import fifo_pkg::*;
#(
    parameter int BITNUMBER = DEFAULT_BITNUMBER,
    parameter int LENGTH    = DEFAULT_LENGTH,
    parameter int CNTW      = calc_cntw(LENGTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Fifo_wr,
    input  logic                 Fifo_rd,
    input  logic [BITNUMBER-1:0] Fifo_Data_in,
    input  logic [CNTW-1:0]      umbral_alto,
    input  logic [CNTW-1:0]      umbral_bajo,
    input  logic                 error_clr,
    output logic [BITNUMBER-1:0] Fifo_Data_out,
    output logic                 Fifo_full,
    output logic                 Fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 Fifo_rd_error,
    output logic                 Fifo_wr_error,
    output logic                 Fifo_error,
    output logic [CNTW-1:0]      Fifo_count
);

    localparam int PTRW = calc_ptrw(LENGTH);

    logic [PTRW-1:0]      wr_ptr;
    logic [PTRW-1:0]      rd_ptr;
    logic [CNTW-1:0]      count;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 rd_reject;
    logic                 wr_reject;
    logic [BITNUMBER-1:0] mem_rd_data;
    fifo_op_e             op;

    fifo_mem #(
        .BITNUMBER (BITNUMBER),
        .LENGTH    (LENGTH),
        .PTRW      (PTRW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (Fifo_Data_in),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    // Status flags come straight from the count register and the live
    // thresholds, so a threshold change is reflected in the same cycle.
    assign Fifo_count   = count;
    assign Fifo_full    = (count == CNTW'(LENGTH));
    assign Fifo_empty   = (count == '0);
    assign almost_full  = (count >= umbral_alto);
    assign almost_empty = (count <= umbral_bajo);

    // A write is allowed into a full FIFO when a read frees the oldest slot
    // in the same cycle. A read from an empty FIFO is never bypassed from
    // the write data, even if a write arrives at the same time.
    always_comb begin
        wr_ok     = Fifo_wr && (!Fifo_full || Fifo_rd);
        rd_ok     = Fifo_rd && !Fifo_empty;
        rd_reject = Fifo_rd && Fifo_empty;
        wr_reject = Fifo_wr && Fifo_full && !Fifo_rd;
        op        = fifo_op_e'({wr_ok, rd_ok});
    end

    // Pointers, occupancy and read data register. Reset empties the FIFO
    // but leaves the storage array untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            Fifo_Data_out <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= PTRW'(ptr_inc(32'(wr_ptr), LENGTH));
            if (rd_ok) begin
                rd_ptr        <= PTRW'(ptr_inc(32'(rd_ptr), LENGTH));
                Fifo_Data_out <= mem_rd_data;
            end
            case (op)
                OP_WRITE: count <= count + CNTW'(1);
                OP_READ:  count <= count - CNTW'(1);
                default:  count <= count;
            endcase
        end
    end

    // Error pulses last exactly one cycle after the rejected request. The
    // sticky flag rises together with the pulse, and a new error outranks
    // a clear requested in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            Fifo_rd_error <= 1'b0;
            Fifo_wr_error <= 1'b0;
            Fifo_error    <= 1'b0;
        end else begin
            Fifo_rd_error <= rd_reject;
            Fifo_wr_error <= wr_reject;
            if (rd_reject || wr_reject)
                Fifo_error <= 1'b1;
            else if (error_clr)
                Fifo_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param
// Directed bench for fifo_param: an 8-deep instance (a_*) exercises fill,
// overflow, drain, simultaneous read/write at full and empty, thresholds
// and mid-stream reset; a 5-deep instance (b_*) exercises pointer wrap on
// a non-power-of-two depth against a reference queue.
module tb_fifo_param;

    logic       clk;
    int         vectors;
    int         miscompares;

    // 8-deep instance
    logic       a_reset, a_wr, a_rd, a_clr;
    logic [7:0] a_din;
    logic [3:0] a_alto, a_bajo;
    logic [7:0] a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_rderr, a_wrerr, a_err;
    logic [3:0] a_count;

    // 5-deep instance
    logic       b_reset, b_wr, b_rd;
    logic [7:0] b_din;
    logic [2:0] b_alto, b_bajo;
    logic [7:0] b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_rderr, b_wrerr, b_err;
    logic [2:0] b_count;

    fifo_param #(.BITNUMBER(8), .LENGTH(8)) dut_a (
        .clk           (clk),
        .reset         (a_reset),
        .Fifo_wr       (a_wr),
        .Fifo_rd       (a_rd),
        .Fifo_Data_in  (a_din),
        .umbral_alto   (a_alto),
        .umbral_bajo   (a_bajo),
        .error_clr     (a_clr),
        .Fifo_Data_out (a_dout),
        .Fifo_full     (a_full),
        .Fifo_empty    (a_empty),
        .almost_full   (a_af),
        .almost_empty  (a_ae),
        .Fifo_rd_error (a_rderr),
        .Fifo_wr_error (a_wrerr),
        .Fifo_error    (a_err),
        .Fifo_count    (a_count)
    );

    fifo_param #(.BITNUMBER(8), .LENGTH(5)) dut_b (
        .clk           (clk),
        .reset         (b_reset),
        .Fifo_wr       (b_wr),
        .Fifo_rd       (b_rd),
        .Fifo_Data_in  (b_din),
        .umbral_alto   (b_alto),
        .umbral_bajo   (b_bajo),
        .error_clr     (1'b0),
        .Fifo_Data_out (b_dout),
        .Fifo_full     (b_full),
        .Fifo_empty    (b_empty),
        .almost_full   (b_af),
        .almost_empty  (b_ae),
        .Fifo_rd_error (b_rderr),
        .Fifo_wr_error (b_wrerr),
        .Fifo_error    (b_err),
        .Fifo_count    (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock on the 8-deep FIFO: drive on the falling edge, sample 1ns
    // after the rising edge.
    task automatic step_a(input logic wr, input logic rd, input logic [7:0] din,
                          input logic clr);
        @(negedge clk);
        a_wr = wr; a_rd = rd; a_din = din; a_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic wr, input logic rd, input logic [7:0] din);
        @(negedge clk);
        b_wr = wr; b_rd = rd; b_din = din;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({a_count, a_empty, a_full, a_ae, a_af} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got cnt=%0d e=%b f=%b ae=%b af=%b, expected cnt=0 e=1 f=0 ae=1 af=0",
                     a_count, a_empty, a_full, a_ae, a_af);
        end
        vectors++;
        if ({a_dout, a_rderr, a_wrerr, a_err} !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got dout=%h rde=%b wre=%b err=%b, expected all 0",
                     a_dout, a_rderr, a_wrerr, a_err);
        end
        @(negedge clk);
        a_reset = 1'b0;
        b_reset = 1'b0;
    endtask

    task automatic test_fill;
        for (int i = 0; i < 8; i++) begin
            step_a(1'b1, 1'b0, 8'h11 + 8'(i), 1'b0);
            vectors++;
            if ({a_count, a_ae, a_af, a_full, a_wrerr, a_err} !==
                {4'(i + 1), (i + 1) <= 2, (i + 1) >= 6, (i + 1) == 8, 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL fill_%0d: got cnt=%0d ae=%b af=%b f=%b wre=%b err=%b, expected cnt=%0d ae=%b af=%b f=%b wre=0 err=0",
                         i, a_count, a_ae, a_af, a_full, a_wrerr, a_err,
                         i + 1, (i + 1) <= 2, (i + 1) >= 6, (i + 1) == 8);
            end
        end
    endtask

    task automatic test_overflow;
        step_a(1'b1, 1'b0, 8'hAA, 1'b0);
        vectors++;
        if ({a_wrerr, a_err, a_count, a_full} !== {1'b1, 1'b1, 4'd8, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL overflow: got wre=%b err=%b cnt=%0d f=%b, expected wre=1 err=1 cnt=8 f=1",
                     a_wrerr, a_err, a_count, a_full);
        end
        step_a(1'b0, 1'b0, 8'h00, 1'b0);
        vectors++;
        if ({a_wrerr, a_err, a_count} !== {1'b0, 1'b1, 4'd8}) begin
            miscompares++;
            $display("[TB] FAIL overflow_after: got wre=%b err=%b cnt=%0d, expected wre=0 err=1 cnt=8",
                     a_wrerr, a_err, a_count);
        end
    endtask

    task automatic test_drain;
        for (int i = 0; i < 8; i++) begin
            step_a(1'b0, 1'b1, 8'h00, 1'b0);
            vectors++;
            if ({a_dout, a_count, a_rderr} !== {8'h11 + 8'(i), 4'(7 - i), 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL drain_%0d: got dout=%h cnt=%0d rde=%b, expected dout=%h cnt=%0d rde=0",
                         i, a_dout, a_count, a_rderr, 8'h11 + 8'(i), 7 - i);
            end
        end
        step_a(1'b0, 1'b0, 8'h00, 1'b0);
        vectors++;
        if ({a_empty, a_dout} !== {1'b1, 8'h18}) begin
            miscompares++;
            $display("[TB] FAIL drain_hold: got e=%b dout=%h, expected e=1 dout=18", a_empty, a_dout);
        end
    endtask

    task automatic test_error_clr;
        step_a(1'b0, 1'b0, 8'h00, 1'b1);
        vectors++;
        if (a_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL error_clr: got err=%b expected 0", a_err);
        end
        step_a(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_full_rdwr;
        logic [7:0] exp_seq [8];
        for (int i = 0; i < 8; i++)
            step_a(1'b1, 1'b0, 8'h11 + 8'(i), 1'b0);
        step_a(1'b1, 1'b1, 8'h55, 1'b0);
        vectors++;
        if ({a_dout, a_count, a_full, a_rderr, a_wrerr, a_err} !==
            {8'h11, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL full_rdwr: got dout=%h cnt=%0d f=%b rde=%b wre=%b err=%b, expected dout=11 cnt=8 f=1 no errors",
                     a_dout, a_count, a_full, a_rderr, a_wrerr, a_err);
        end
        exp_seq = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55};
        for (int i = 0; i < 8; i++) begin
            step_a(1'b0, 1'b1, 8'h00, 1'b0);
            vectors++;
            if (a_dout !== exp_seq[i]) begin
                miscompares++;
                $display("[TB] FAIL full_rdwr_drain_%0d: got %h expected %h", i, a_dout, exp_seq[i]);
            end
        end
    endtask

    task automatic test_empty_rdwr;
        // error_clr asserted in the same cycle as the new error: set must win
        step_a(1'b1, 1'b1, 8'h3C, 1'b1);
        vectors++;
        if ({a_rderr, a_err, a_count, a_dout} !== {1'b1, 1'b1, 4'd1, 8'h55}) begin
            miscompares++;
            $display("[TB] FAIL empty_rdwr: got rde=%b err=%b cnt=%0d dout=%h, expected rde=1 err=1 cnt=1 dout=55",
                     a_rderr, a_err, a_count, a_dout);
        end
        step_a(1'b0, 1'b1, 8'h00, 1'b0);
        vectors++;
        if ({a_dout, a_count, a_rderr, a_err} !== {8'h3C, 4'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL empty_rdwr_next: got dout=%h cnt=%0d rde=%b err=%b, expected dout=3c cnt=0 rde=0 err=1",
                     a_dout, a_count, a_rderr, a_err);
        end
    endtask

    task automatic test_thresholds;
        logic [3:0] alto_v [3];
        logic       af_exp [3];
        logic [3:0] bajo_v [3];
        logic       ae_exp [3];
        for (int i = 0; i < 3; i++)
            step_a(1'b1, 1'b0, 8'h01 + 8'(i), 1'b0);
        step_a(1'b0, 1'b0, 8'h00, 1'b0);
        // occupancy is 3 throughout
        alto_v = '{4'd0, 4'd3, 4'd4};
        af_exp = '{1'b1, 1'b1, 1'b0};
        bajo_v = '{4'd8, 4'd3, 4'd2};
        ae_exp = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_alto = alto_v[i];
            a_bajo = bajo_v[i];
            #1;
            vectors++;
            if ({a_af, a_ae} !== {af_exp[i], ae_exp[i]}) begin
                miscompares++;
                $display("[TB] FAIL thresh_%0d: got af=%b ae=%b, expected af=%b ae=%b",
                         i, a_af, a_ae, af_exp[i], ae_exp[i]);
            end
        end
        @(negedge clk);
        a_alto = 4'd6;
        a_bajo = 4'd2;
    endtask

    task automatic test_mid_reset;
        step_a(1'b1, 1'b0, 8'h04, 1'b0);
        vectors++;
        if ({a_count, a_err} !== {4'd4, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL pre_reset: got cnt=%0d err=%b, expected cnt=4 err=1", a_count, a_err);
        end
        @(negedge clk);
        a_reset = 1'b1;
        a_wr = 1'b1; a_rd = 1'b1; a_din = 8'h99;
        @(posedge clk);
        #1;
        vectors++;
        if ({a_count, a_empty, a_err, a_dout, a_rderr, a_wrerr} !==
            {4'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got cnt=%0d e=%b err=%b dout=%h rde=%b wre=%b, expected cnt=0 e=1 err=0 dout=00 no pulses",
                     a_count, a_empty, a_err, a_dout, a_rderr, a_wrerr);
        end
        @(negedge clk);
        a_reset = 1'b0;
        a_wr = 1'b0; a_rd = 1'b0;
        step_a(1'b1, 1'b0, 8'h77, 1'b0);
        step_a(1'b0, 1'b1, 8'h00, 1'b0);
        vectors++;
        if ({a_dout, a_count, a_empty} !== {8'h77, 4'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL post_reset: got dout=%h cnt=%0d e=%b, expected dout=77 cnt=0 e=1",
                     a_dout, a_count, a_empty);
        end
    endtask

    // Non-power-of-two depth: 18 writes through a 5-entry FIFO wrap both
    // pointers several times; a queue supplies the expected order.
    task automatic test_wrap;
        logic [7:0] ref_q [$];
        logic [7:0] exp_out;
        logic       wr, rd;
        logic [7:0] din;
        int         bad;
        exp_out = 8'h00;
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            wr  = (k < 24) && ((k % 4) != 3);
            rd  = (k >= 4) && (((k % 2) == 0) || (k >= 24));
            din = 8'(k * 7 + 3);
            step_b(wr, rd, din);
            if (rd && ref_q.size() > 0) begin
                exp_out = ref_q.pop_front();
                if (wr) ref_q.push_back(din);
            end else if (wr && ref_q.size() < 5) begin
                ref_q.push_back(din);
            end
            vectors++;
            if ({b_dout, b_count, b_full} !== {exp_out, 3'(ref_q.size()), ref_q.size() == 5}
                || b_count > 3'd5) begin
                miscompares++;
                $display("[TB] FAIL wrap_%0d: got dout=%h cnt=%0d f=%b, expected dout=%h cnt=%0d f=%b",
                         k, b_dout, b_count, b_full, exp_out, ref_q.size(), ref_q.size() == 5);
            end
        end
        vectors++;
        if (b_empty !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wrap_end_empty: got %b expected 1", b_empty);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        a_reset = 1'b1; a_wr = 1'b0; a_rd = 1'b0; a_din = 8'h00; a_clr = 1'b0;
        a_alto = 4'd6; a_bajo = 4'd2;
        b_reset = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_din = 8'h00;
        b_alto = 3'd4; b_bajo = 3'd1;
        $display("[TB] starting fifo_param bench");
        test_reset;
        test_fill;
        test_overflow;
        test_drain;
        test_error_clr;
        test_full_rdwr;
        test_empty_rdwr;
        test_thresholds;
        test_mid_reset;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
